// File: rtl/tdc_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tdc_fifo_arbiter
// Description : Round-robin burst arbiter merging N_SRC FWFT word sources
//               into one FIFO-read interface. Optional macro
//               TDC_FIFO_ARBITER_SOURCE_TAG_EN tags FIFO_DATA[DATA_W-1 -: 4]
//               with the granted source index.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_fifo_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 16,
  parameter int DATA_W    = 32
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic [N_SRC-1:0]        SRC_EN,
  input  logic [N_SRC-1:0]        SRC_EMPTY,
  input  logic [N_SRC*DATA_W-1:0] SRC_DATA,
  output logic [N_SRC-1:0]        SRC_READ,
  input  logic                    FIFO_READ,
  output logic                    FIFO_EMPTY,
  output logic [DATA_W-1:0]       FIFO_DATA,
  output logic [N_SRC-1:0]        GRANT,
  output logic [15:0]             BURST_CNT
);

  localparam int               IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_SRC - 1);
  localparam logic [15:0]      BURST_MAX = 16'(MAX_BURST);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_SRC-1:0]   grant, grant_nxt;
  logic [15:0]        burst_cnt, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   pick, cand;
  logic               found;
  logic [N_SRC-1:0]   req;
  logic [DATA_W-1:0]  words [N_SRC];
  logic [DATA_W-1:0]  word_g, fifo_word;
  logic               granted, src_empty_g, pop;

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign words[i] = SRC_DATA[i*DATA_W +: DATA_W];
    end
  endgenerate

  assign req         = SRC_EN & ~SRC_EMPTY;
  assign granted     = (state == S_GRANT);
  assign src_empty_g = SRC_EMPTY[gidx];
  assign word_g      = words[gidx];
  assign pop         = granted & FIFO_READ & ~src_empty_g;
  assign cnt_inc     = burst_cnt + 16'd1;

  // Rotating search starting just after the last granted source.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((int'(last) + k) % N_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = burst_cnt;
    last_nxt  = last;
    gidx_nxt  = gidx;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt       = S_GRANT;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          cnt_nxt         = '0;
          gidx_nxt        = pick;
        end
      end
      S_GRANT: begin
        if (pop) begin
          cnt_nxt = cnt_inc;
        end
        if ((pop && cnt_inc == BURST_MAX) || src_empty_g) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state     <= S_IDLE;
      grant     <= '0;
      burst_cnt <= '0;
      last      <= LAST_RST;
      gidx      <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      burst_cnt <= cnt_nxt;
      last      <= last_nxt;
      gidx      <= gidx_nxt;
    end
  end

  always_comb begin
    fifo_word = word_g;
`ifdef TDC_FIFO_ARBITER_SOURCE_TAG_EN
    fifo_word[DATA_W-1 -: 4] = 4'(gidx);
`endif
  end

  // Reset drops state to IDLE asynchronously, which also kills any pop in flight.
  assign SRC_READ   = grant & {N_SRC{pop}};
  assign FIFO_EMPTY = granted ? src_empty_g : 1'b1;
  assign FIFO_DATA  = granted ? fifo_word : '0;
  assign GRANT      = grant;
  assign BURST_CNT  = burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tdc_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_fifo_arbiter
// Description : Self-checking bench for tdc_fifo_arbiter (N_SRC=4, MAX_BURST=4)
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_fifo_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int W  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en, empty, sread, grant;
  logic [N*W-1:0] sdata;
  logic           rd, fempty;
  logic [W-1:0]   fdata;
  logic [15:0]    bcnt;

  always #5 clk = ~clk;

  tdc_fifo_arbiter #(.N_SRC(N), .MAX_BURST(MB), .DATA_W(W)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .SRC_EN(en), .SRC_EMPTY(empty),
    .SRC_DATA(sdata), .SRC_READ(sread), .FIFO_READ(rd), .FIFO_EMPTY(fempty),
    .FIFO_DATA(fdata), .GRANT(grant), .BURST_CNT(bcnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-source word queues plus owner / burst / last-winner.
  logic [31:0] mem [N][1024];
  int          wp [N];
  int          rp [N];
  logic [31:0] drv [N];
  int          owner, cnt, mlast;
  logic [31:0] got [$];

  function automatic int sz(input int s);
    return wp[s] - rp[s];
  endfunction

  function automatic logic [31:0] tagw(input int s, input logic [31:0] w);
`ifdef TDC_FIFO_ARBITER_SOURCE_TAG_EN
    return {4'(s), w[27:0]};
`else
    return w;
`endif
  endfunction

  function automatic bit all_empty();
    for (int s = 0; s < N; s++) if (sz(s) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int s, input logic [31:0] w);
    mem[s][wp[s]] = w;
    wp[s]++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      empty[s] = (sz(s) == 0);
      drv[s]   = (sz(s) != 0) ? mem[s][rp[s]] : (32'hDEAD_BEE0 | 32'(s));
      sdata[s*W +: W] = drv[s];
    end
  endtask

  // One clock cycle: called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic [N-1:0] e, input logic r);
    logic [31:0] eg, er, ed;
    logic        ee;
    en = e;
    rd = r;
    drive();
    #3;
    eg = (owner < 0) ? 32'd0 : (32'd1 << owner);
    ee = (owner < 0) ? 1'b1 : (sz(owner) == 0);
    ed = (owner < 0) ? 32'd0 : tagw(owner, drv[owner]);
    er = (owner >= 0 && r && sz(owner) > 0) ? (32'd1 << owner) : 32'd0;
    chk("grant", 32'(grant), eg);
    chk("fifo_empty", 32'(fempty), 32'(ee));
    chk("fifo_data", fdata, ed);
    chk("src_read", 32'(sread), er);
    chk("burst_cnt", 32'(bcnt), 32'(cnt));
    if (rd && !fempty) got.push_back(fdata);
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (owner < 0 && e[(mlast + k) % N] && sz((mlast + k) % N) > 0) begin
          owner = (mlast + k) % N;
          cnt   = 0;
        end
      end
    end else if (r && sz(owner) > 0) begin
      rp[owner]++;
      cnt++;
      if (cnt == MB) begin
        mlast = owner;
        owner = -1;
      end
    end else if (sz(owner) == 0) begin
      mlast = owner;
      owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && !(all_empty() && owner < 0); c++) cycle(4'hF, 1'b1);
    chk("drained", 32'(all_empty()), 32'd1);
  endtask

  initial begin
    int start, j, src, idx;
    rst   = 1'b1;
    en    = '0;
    rd    = 1'b0;
    empty = '1;
    sdata = '0;
    owner = -1;
    cnt   = 0;
    mlast = N - 1;
    for (int s = 0; s < N; s++) begin
      wp[s] = 0;
      rp[s] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cnt", 32'(bcnt), 32'd0);
    chk("rst_empty", 32'(fempty), 32'd1);
    chk("rst_data", fdata, 32'd0);
    chk("rst_read", 32'(sread), 32'd0);
    rst = 1'b0;

    // Single source, two bursts separated by a dead cycle.
    for (int k = 0; k < 6; k++) push(2, 32'hA0 + 32'(k));
    got.delete();
    repeat (12) cycle(4'hF, 1'b1);
    chk("t1_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk("t1_word", got[k], tagw(2, 32'hA0 + 32'(k)));

    // Fairness: round-robin bursts of MB words.
    start = (mlast + 1) % N;
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 8; k++) push(s, 32'h0000_0000 | (32'(s) << 8) | 32'(k));
    got.delete();
    for (int c = 0; c < 120 && !all_empty(); c++) cycle(4'hF, 1'b1);
    chk("t2_count", 32'(got.size()), 32'd32);
    for (j = 0; j < 32 && j < got.size(); j++) begin
      src = (start + (j % 16) / MB) % N;
      idx = (j / 16) * MB + (j % MB);
      chk("t2_order", {16'd0, got[j][15:0]}, (32'(src) << 8) | 32'(idx));
    end
    drain();

    // Mask 1010, then drop source 1 mid-burst.
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 8; k++) push(s, $urandom);
    for (int c = 0; c < 60 && !(owner == 1 && cnt == 1); c++) cycle(4'b1010, 1'b1);
    chk("t3_midburst", 32'(owner), 32'd1);
    repeat (20) cycle(4'b1000, 1'b1);
    drain();

    // Source empties after one word, then sink stalls.
    push(0, 32'h0000_0C01);
    for (int k = 0; k < 3; k++) push(1, 32'h0000_0D00 + 32'(k));
    repeat (3) cycle(4'hF, 1'b1);
    repeat (5) cycle(4'hF, 1'b0);
    chk("t4_stall_cnt", 32'(bcnt), 32'd0);
    repeat (6) cycle(4'hF, 1'b1);
    drain();

    // Asynchronous reset mid-burst.
    for (int k = 0; k < 8; k++) begin
      push(0, $urandom);
      push(2, $urandom);
    end
    for (int c = 0; c < 40 && !(owner >= 0 && cnt == 3); c++) cycle(4'hF, 1'b1);
    chk("t5_cnt3", 32'(bcnt), 32'd3);
    en = 4'hF;
    rd = 1'b1;
    drive();
    #1;
    rst = 1'b1;
    #1;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_empty", 32'(fempty), 32'd1);
    chk("t5_read", 32'(sread), 32'd0);
    chk("t5_cnt", 32'(bcnt), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    owner = -1;
    cnt   = 0;
    mlast = N - 1;
    cycle(4'hF, 1'b1);
    chk("t5_first_grant", 32'(grant), 32'd1);
    drain();

    // Source tag on source 3.
    push(3, 32'h1234_5678);
    cycle(4'hF, 1'b0);
    en = 4'hF;
    rd = 1'b0;
    drive();
    #1;
`ifdef TDC_FIFO_ARBITER_SOURCE_TAG_EN
    chk("t6_tag", fdata, 32'h3234_5678);
`else
    chk("t6_tag", fdata, 32'h1234_5678);
`endif
    cycle(4'hF, 1'b0);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 9) < 3 && wp[s] < 1000) push(s, $urandom);
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
